// File: rtl/pwm_axil_slave.sv
// AXI4-Lite slave front end for the PWM register file: terminates AW/W/B and AR/R
// and drives the register file's single-cycle write port and combinational read port.
module pwm_axil_slave #(
  parameter int NUM_CHANNELS   = 4,
  parameter int AXI_ADDR_WIDTH = 8,
  localparam int REG_ADDR_WIDTH = $clog2(1 + 2*NUM_CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [31:0]               s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      write_en,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]               write_data,
  output logic                      read_en,
  output logic [REG_ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]               read_data,
  input  logic                      read_valid
);

  localparam int DEPTH = 1 + 2*NUM_CHANNELS;
  localparam logic [REG_ADDR_WIDTH-1:0] DEPTH_IDX = REG_ADDR_WIDTH'(DEPTH);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_ISSUE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_READ  = 2'd1;
  localparam logic [1:0] R_RESP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]                w_state;
  logic [1:0]                r_state;
  logic                      aw_held;
  logic                      w_held;
  logic [REG_ADDR_WIDTH-1:0] aw_idx;
  logic                      aw_ok;
  logic [31:0]               w_data;
  logic                      w_strb_ok;
  logic [REG_ADDR_WIDTH-1:0] ar_idx;
  logic                      ar_ok;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;
  logic                      aw_in_range;
  logic                      ar_in_range;
  logic                      unused_bits;

  // Byte lanes 3:2 and the sub-word address bits carry no information for 16-bit registers.
  assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_wstrb[3:2]};

  assign aw_in_range = ((s_axil_awaddr >> (REG_ADDR_WIDTH + 2)) == '0) &&
                       (s_axil_awaddr[REG_ADDR_WIDTH+1:2] < DEPTH_IDX);
  assign ar_in_range = ((s_axil_araddr >> (REG_ADDR_WIDTH + 2)) == '0) &&
                       (s_axil_araddr[REG_ADDR_WIDTH+1:2] < DEPTH_IDX);

  assign s_axil_awready = (w_state == W_IDLE) && !aw_held;
  assign s_axil_wready  = (w_state == W_IDLE) && !w_held;
  assign s_axil_bvalid  = (w_state == W_RESP);
  assign aw_hs          = s_axil_awvalid && s_axil_awready;
  assign w_hs           = s_axil_wvalid && s_axil_wready;

  assign write_en   = (w_state == W_ISSUE) && aw_ok && w_strb_ok;
  assign write_addr = aw_idx;
  assign write_data = w_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      aw_ok        <= 1'b0;
      w_data       <= '0;
      w_strb_ok    <= 1'b0;
      s_axil_bresp <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= s_axil_awaddr[REG_ADDR_WIDTH+1:2];
            aw_ok   <= aw_in_range;
          end
          if (w_hs) begin
            w_held    <= 1'b1;
            w_data    <= s_axil_wdata;
            w_strb_ok <= (s_axil_wstrb[1:0] == 2'b11);
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            w_state <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          s_axil_bresp <= (aw_ok && w_strb_ok) ? RESP_OKAY : RESP_SLVERR;
          aw_held      <= 1'b0;
          w_held       <= 1'b0;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axil_bready) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign s_axil_arready = (r_state == R_IDLE);
  assign s_axil_rvalid  = (r_state == R_RESP);
  assign ar_hs          = s_axil_arvalid && s_axil_arready;
  assign read_en        = (r_state == R_READ) && ar_ok;
  assign read_addr      = ar_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= R_IDLE;
      ar_idx       <= '0;
      ar_ok        <= 1'b0;
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_idx  <= s_axil_araddr[REG_ADDR_WIDTH+1:2];
            ar_ok   <= ar_in_range;
            r_state <= R_READ;
          end
        end
        R_READ: begin
          // A register file that fails to answer an in-range read is reported as SLVERR.
          if (ar_ok) begin
            s_axil_rdata <= read_data;
            s_axil_rresp <= read_valid ? RESP_OKAY : RESP_SLVERR;
          end else begin
            s_axil_rdata <= '0;
            s_axil_rresp <= RESP_SLVERR;
          end
          r_state <= R_RESP;
        end
        R_RESP: begin
          if (s_axil_rready) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_axil_slave.sv
// Self-checking bench for pwm_axil_slave: directed AXI-Lite cases plus randomized
// concurrent read/write traffic checked against a shadow register model.
module tb_pwm_axil_slave;

  localparam int DEPTH = 9;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_axil_awaddr;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [7:0]  s_axil_araddr;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        read_en;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic        read_valid;

  pwm_axil_slave #(.NUM_CHANNELS(4), .AXI_ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: written on the clock edge, read combinationally.
  logic [31:0] rf [DEPTH];
  logic        rv_low;
  always @(posedge clk) if (write_en && write_addr < DEPTH) rf[write_addr] <= write_data;
  assign read_data  = (read_en && read_addr < DEPTH) ? rf[read_addr] : 32'h0;
  assign read_valid = read_en && (read_addr < DEPTH) && !rv_low;

  // Shadow of what the register file must hold, plus writes still owed to it.
  typedef struct packed { logic [3:0] idx; logic [31:0] data; } wr_t;
  logic [31:0] mdl [DEPTH];
  wr_t         exp_wr[$];
  logic [3:0]  last_wa;
  logic [31:0] last_wd;

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit a_ok(input logic [7:0] a);
    return (int'(a) / 4) < DEPTH;
  endfunction

  function automatic bit wr_ok(input logic [7:0] a, input logic [3:0] strb);
    return a_ok(a) && strb[0] && strb[1];
  endfunction

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    a = 8'($urandom);
    if ($urandom % 3 != 0) a = 8'(($urandom % DEPTH) * 4 + ($urandom % 4));
    return a;
  endfunction

  always @(negedge clk) begin
    if (rst_n && write_en) begin
      if (exp_wr.size() == 0) begin
        chk("stray_write_en", 32'(write_en), 32'd0);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("write_addr", 32'(write_addr), 32'(e.idx));
        chk("write_data", write_data, e.data);
        last_wa = write_addr;
        last_wd = write_data;
      end
    end
  end

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int unsigned aw_dly, input int unsigned w_dly,
                          input int unsigned b_stall);
    bit  ok;
    wr_t e;
    ok = wr_ok(addr, strb);
    fork
      begin
        bit got = 1'b0;
        repeat (aw_dly) @(negedge clk);
        s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
          if (n > 0) @(negedge clk);
          got = s_axil_awready;
          @(posedge clk);
        end
        chk("aw_handshake", 32'(got), 32'd1);
        if (aw_dly < w_dly) begin
          @(negedge clk);
          chk("awready_drop", 32'(s_axil_awready), 32'd0);
        end
      end
      begin
        bit got = 1'b0;
        repeat (w_dly) @(negedge clk);
        s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
          if (n > 0) @(negedge clk);
          got = s_axil_wready;
          @(posedge clk);
        end
        chk("w_handshake", 32'(got), 32'd1);
        if (w_dly < aw_dly) begin
          @(negedge clk);
          chk("wready_drop", 32'(s_axil_wready), 32'd0);
        end
      end
    join
    if (ok) begin
      e.idx = 4'(addr / 4); e.data = data;
      exp_wr.push_back(e);
    end
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("write_en_c1", 32'(write_en), 32'(ok));
    chk("bvalid_c1", 32'(s_axil_bvalid), 32'd0);
    chk("awready_issue", 32'(s_axil_awready), 32'd0);
    @(negedge clk);
    chk("bvalid_c2", 32'(s_axil_bvalid), 32'd1);
    chk("bresp", 32'(s_axil_bresp), ok ? 32'd0 : 32'd2);
    for (int i = 0; i < int'(b_stall); i++) begin
      @(negedge clk);
      chk("bvalid_stall", 32'(s_axil_bvalid), 32'd1);
      chk("bresp_stall", 32'(s_axil_bresp), ok ? 32'd0 : 32'd2);
      chk("wready_stall", 32'(s_axil_wready), 32'd0);
    end
    s_axil_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axil_bready = 1'b0;
    chk("bvalid_done", 32'(s_axil_bvalid), 32'd0);
    chk("awready_idle", 32'(s_axil_awready), 32'd1);
    chk("wready_idle", 32'(s_axil_wready), 32'd1);
    if (ok) mdl[addr / 4] = data;
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data, input bit chk_data,
                         input int unsigned dly, input int unsigned r_stall);
    bit         got = 1'b0;
    bit         inr;
    logic [1:0] exp_resp;
    inr      = a_ok(addr);
    exp_resp = (inr && !rv_low) ? 2'b00 : 2'b10;
    repeat (dly) @(negedge clk);
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      if (n > 0) @(negedge clk);
      got = s_axil_arready;
      @(posedge clk);
    end
    chk("ar_handshake", 32'(got), 32'd1);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    chk("read_en_c1", 32'(read_en), 32'(inr));
    if (inr) chk("read_addr", 32'(read_addr), 32'(addr / 4));
    chk("arready_read", 32'(s_axil_arready), 32'd0);
    @(negedge clk);
    chk("rvalid_c2", 32'(s_axil_rvalid), 32'd1);
    if (chk_data) chk("rdata", s_axil_rdata, exp_data);
    chk("rresp", 32'(s_axil_rresp), 32'(exp_resp));
    for (int i = 0; i < int'(r_stall); i++) begin
      @(negedge clk);
      chk("rvalid_stall", 32'(s_axil_rvalid), 32'd1);
      if (chk_data) chk("rdata_stall", s_axil_rdata, exp_data);
      chk("rresp_stall", 32'(s_axil_rresp), 32'(exp_resp));
      chk("arready_stall", 32'(s_axil_arready), 32'd0);
    end
    s_axil_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axil_rready = 1'b0;
    chk("rvalid_done", 32'(s_axil_rvalid), 32'd0);
    chk("arready_idle", 32'(s_axil_arready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at t=%0t, expected to have finished", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rv_low = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin rf[i] = '0; mdl[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(s_axil_awready), 32'd1);
    chk("rst_wready", 32'(s_axil_wready), 32'd1);
    chk("rst_arready", 32'(s_axil_arready), 32'd1);
    chk("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_read_en", 32'(read_en), 32'd0);
    chk("rst_bresp", 32'(s_axil_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axil_rresp), 32'd0);
    chk("rst_rdata", s_axil_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_write(8'h04, 32'h0000ABCD, 4'hF, 0, 0, 0);
    chk("lit_write_idx", 32'(last_wa), 32'd1);
    chk("lit_write_data", last_wd, 32'h0000ABCD);
    do_write(8'h08, 32'h5555_0002, 4'hF, 2, 0, 1);
    chk("lit_wfirst_idx", 32'(last_wa), 32'd2);
    do_write(8'h24, 32'hDEAD_0009, 4'hF, 0, 0, 0);
    do_write(8'h10, 32'hDEAD_0004, 4'h1, 1, 0, 0);
    do_read(8'h10, 32'h0000_0000, 1'b1, 0, 0);
    do_read(8'h24, 32'h0000_0000, 1'b1, 0, 0);
    do_write(8'h00, 32'h0000_0010, 4'hF, 0, 1, 0);
    do_read(8'h00, 32'h0000_0010, 1'b1, 0, 0);
    do_read(8'h30, 32'h0000_0000, 1'b1, 0, 0);
    do_read(8'h04, 32'h0000_ABCD, 1'b1, 0, 5);

    rv_low = 1'b1;
    do_read(8'h08, 32'h0, 1'b0, 0, 0);
    rv_low = 1'b0;

    // Same index written and read in the same cycle: the read sees the old value.
    fork
      do_write(8'h04, 32'h1234_5678, 4'hF, 0, 0, 0);
      do_read(8'h04, 32'h0000_ABCD, 1'b1, 0, 0);
    join
    do_read(8'h05, 32'h1234_5678, 1'b1, 0, 0);

    // Reset while the write is in its response phase and the read is mid-lookup.
    s_axil_awaddr = 8'h0C; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hCAFE_0003; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    exp_wr.push_back('{idx: 4'd3, data: 32'hCAFE_0003});
    @(posedge clk);
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 8'h00; s_axil_arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    chk("rstmid_bvalid_pre", 32'(s_axil_bvalid), 32'd1);
    chk("rstmid_read_en_pre", 32'(read_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_bvalid", 32'(s_axil_bvalid), 32'd0);
    chk("rstmid_rvalid", 32'(s_axil_rvalid), 32'd0);
    chk("rstmid_read_en", 32'(read_en), 32'd0);
    chk("rstmid_write_en", 32'(write_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl[3] = 32'hCAFE_0003;
    @(negedge clk);
    chk("rstmid_awready", 32'(s_axil_awready), 32'd1);
    chk("rstmid_wready", 32'(s_axil_wready), 32'd1);
    chk("rstmid_arready", 32'(s_axil_arready), 32'd1);
    chk("rstmid_rvalid_after", 32'(s_axil_rvalid), 32'd0);
    do_read(8'h0C, 32'hCAFE_0003, 1'b1, 0, 0);

    for (int it = 0; it < 150; it++) begin
      logic [7:0]  wa;
      logic [7:0]  ra;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] rexp;
      wa = rand_addr();
      ra = rand_addr();
      wd = $urandom;
      ws = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
      if (wr_ok(wa, ws) && a_ok(ra) && (ra / 4 == wa / 4)) ra = ra | 8'h80;
      rexp = a_ok(ra) ? mdl[ra / 4] : 32'h0;
      fork
        do_write(wa, wd, ws, $urandom % 3, $urandom % 3, $urandom % 3);
        do_read(ra, rexp, 1'b1, $urandom % 3, $urandom % 3);
      join
    end

    for (int i = 0; i < DEPTH; i++) do_read(8'(i * 4), mdl[i], 1'b1, 0, 0);
    chk("pending_writes", 32'(exp_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
